// File: rtl/mips_rtype_pkg.sv
// mips_rtype_pkg: shared opcode/funct constants, ALU select encoding and ALU flag bundle
package mips_rtype_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLTU = 6'h2B;
  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_NOR = 3'b100,
    ALU_SRL = 3'b101,
    ALU_SLL = 3'b110,
    ALU_XOR = 3'b111
  } alu_op_t;
  typedef struct packed {
    logic sum_cout;
    logic sub_borrow;
    logic zero;
    logic sum_ovf;
    logic sub_ovf;
  } alu_flags_t;
endpackage

// File: rtl/alu32.sv
// alu32: 32-bit ALU with 8:1 function select plus carry/borrow, zero and overflow flags
//   a, b, ctrl, arith (srl arithmetic when 1) -> y, flags
module alu32
  import mips_rtype_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  alu_op_t     ctrl,
  input  logic        arith,
  output logic [31:0] y,
  output alu_flags_t  flags
);
  logic [32:0] sum, diff;
  logic [31:0] srl_y;
  assign sum   = {1'b0, a} + {1'b0, b};
  // bit 32 of the widened difference is the borrow of a - b
  assign diff  = {1'b0, a} - {1'b0, b};
  assign srl_y = arith ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
  always_comb
    case (ctrl)
      ALU_ADD: y = sum[31:0];
      ALU_SUB: y = diff[31:0];
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_NOR: y = ~(a | b);
      ALU_SRL: y = srl_y;
      ALU_SLL: y = a << b[4:0];
      default: y = a ^ b;
    endcase
  assign flags.sum_cout   = sum[32];
  assign flags.sub_borrow = diff[32];
  assign flags.zero       = (y == '0);
  assign flags.sum_ovf    = (a[31] == b[31]) && (sum[31] != a[31]);
  assign flags.sub_ovf    = (a[31] != b[31]) && (diff[31] != a[31]);
endmodule

// File: rtl/control_unit.sv
// control_unit: decodes opcode/funct into ALU select, operand-mux and write-enable controls
//   opcode, funct -> alu_ctrl, shift (A=rt, B=shamt), sltu (result from borrow), reg_write
module control_unit
  import mips_rtype_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output alu_op_t    alu_ctrl,
  output logic       shift,
  output logic       sltu,
  output logic       reg_write
);
  logic known;
  always_comb begin
    alu_ctrl = ALU_ADD;
    shift    = 1'b0;
    sltu     = 1'b0;
    known    = 1'b1;
    case (funct)
      F_ADD, F_ADDU: alu_ctrl = ALU_ADD;
      F_SUB, F_SUBU: alu_ctrl = ALU_SUB;
      F_AND:         alu_ctrl = ALU_AND;
      F_OR:          alu_ctrl = ALU_OR;
      F_NOR:         alu_ctrl = ALU_NOR;
      F_SLTU: begin
        alu_ctrl = ALU_SUB;
        sltu     = 1'b1;
      end
      F_SLL: begin
        alu_ctrl = ALU_SLL;
        shift    = 1'b1;
      end
      F_SRL: begin
        alu_ctrl = ALU_SRL;
        shift    = 1'b1;
      end
      default: known = 1'b0;
    endcase
    reg_write = known && (opcode == OP_RTYPE);
  end
endmodule

// File: rtl/mips_registers.sv
// mips_registers: 32x32 register file, two async read ports, one sync write port, $0 hardwired to 0
//   clk, rst_n (async active-low clear), ra/rb -> da/db, we/wa/wd write port
module mips_registers (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  ra,
  input  logic [4:0]  rb,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  output logic [31:0] da,
  output logic [31:0] db
);
  logic [31:0] regs [0:31];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    else if (we && wa != 5'd0)
      regs[wa] <= wd;
  assign da = (ra == 5'd0) ? '0 : regs[ra];
  assign db = (rb == 5'd0) ? '0 : regs[rb];
endmodule

// File: rtl/mips_rtype_datapath.sv
// mips_rtype_datapath: single-cycle R-type execute/writeback core (control, register file, ALU)
//   clk, rst_n (async active-low), instruction -> result (combinational, written to rd on clk rise)
module mips_rtype_datapath
  import mips_rtype_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instruction,
  output logic [31:0] result
);
  alu_op_t     alu_ctrl;
  alu_flags_t  flags;
  logic        shift, sltu, reg_write;
  logic [31:0] rs_data, rt_data, a, b, y;
  control_unit u_ctrl (
    .opcode    (instruction[31:26]),
    .funct     (instruction[5:0]),
    .alu_ctrl  (alu_ctrl),
    .shift     (shift),
    .sltu      (sltu),
    .reg_write (reg_write)
  );
  mips_registers u_regs (
    .clk   (clk),
    .rst_n (rst_n),
    .ra    (instruction[25:21]),
    .rb    (instruction[20:16]),
    .we    (reg_write),
    .wa    (instruction[15:11]),
    .wd    (result),
    .da    (rs_data),
    .db    (rt_data)
  );
  assign a = shift ? rt_data : rs_data;
  assign b = shift ? {27'b0, instruction[10:6]} : rt_data;
  alu32 u_alu (
    .a     (a),
    .b     (b),
    .ctrl  (alu_ctrl),
    .arith (1'b0),
    .y     (y),
    .flags (flags)
  );
  assign result = !reg_write ? '0 : sltu ? {31'b0, flags.sub_borrow} : y;
endmodule

// File: tb/tb_mips_rtype_datapath.sv
// tb_mips_rtype_datapath: directed and randomized checks of the R-type datapath against a register-array model
module tb_mips_rtype_datapath;
  logic        clk = 0;
  logic        rst_n = 0;
  logic [31:0] instruction = '0;
  logic [31:0] result;
  int          n_cmp = 0, n_err = 0;
  logic [31:0] m [0:31];
  logic [5:0]  fns [10] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h27, 6'h2B, 6'h00, 6'h02};

  mips_rtype_datapath dut (.clk(clk), .rst_n(rst_n), .instruction(instruction), .result(result));

  always #5 clk = ~clk;

  function automatic logic [31:0] enc(input logic [5:0] fn, input int rs, input int rt, input int rd, input int sh);
    logic [4:0] s = rs[4:0], t = rt[4:0], d = rd[4:0], h = sh[4:0];
    return {6'b0, s, t, d, h, fn};
  endfunction

  function automatic logic [31:0] rd_reg(input int r);
    return enc(6'h25, r, 0, 0, 0);
  endfunction

  function automatic logic [31:0] model(input logic [31:0] ins);
    logic [31:0] s = m[ins[25:21]], t = m[ins[20:16]];
    int sh = int'(ins[10:6]);
    if (ins[31:26] != 0) return 0;
    case (ins[5:0])
      6'h20, 6'h21: return s + t;
      6'h22, 6'h23: return s - t;
      6'h24: return s & t;
      6'h25: return s | t;
      6'h27: return ~(s | t);
      6'h2B: return (s < t) ? 32'd1 : 32'd0;
      6'h00: return t << sh;
      6'h02: return t >> sh;
      default: return 0;
    endcase
  endfunction

  function automatic bit writes(input logic [31:0] ins);
    if (ins[31:26] != 0) return 0;
    foreach (fns[i]) if (fns[i] == ins[5:0]) return ins[15:11] != 0;
    return 0;
  endfunction

  task automatic clock_in(input logic [31:0] ins);
    logic [31:0] v = model(ins);
    @(posedge clk);
    #1;
    if (writes(ins)) m[ins[15:11]] = v;
  endtask

  task automatic test_reset;
    instruction = enc(6'h27, 0, 0, 1, 0);
    #1;
    n_cmp++;
    if (result !== 32'hFFFFFFFF) begin n_err++; $display("FAIL reset_nor got=%h want=ffffffff", result); end
    instruction = enc(6'h20, 0, 0, 1, 0);
    #1;
    n_cmp++;
    if (result !== 32'h0) begin n_err++; $display("FAIL reset_add got=%h want=00000000", result); end
    @(posedge clk);
    #1;
    instruction = rd_reg(1);
    #1;
    n_cmp++;
    if (result !== 32'h0) begin n_err++; $display("FAIL reset_blocks_write got=%h want=00000000", result); end
    rst_n = 1;
    foreach (m[i]) m[i] = 0;
  endtask

  task automatic test_directed;
    logic [31:0] ins [21] = '{
      enc(6'h27, 0, 0, 1, 0),  enc(6'h02, 0, 1, 2, 28), enc(6'h00, 0, 2, 6, 31), enc(6'h00, 0, 2, 10, 0),
      enc(6'h20, 2, 2, 3, 0),  enc(6'h22, 2, 3, 4, 0),  enc(6'h20, 1, 1, 7, 0),  enc(6'h24, 1, 2, 8, 0),
      enc(6'h25, 3, 2, 9, 0),  enc(6'h2B, 2, 3, 5, 0),  enc(6'h2B, 3, 2, 5, 0),  enc(6'h2B, 2, 2, 5, 0),
      enc(6'h2B, 0, 1, 5, 0),  rd_reg(7),               rd_reg(6),               enc(6'h27, 0, 0, 0, 0),
      rd_reg(0),               enc(6'h3F, 1, 2, 1, 0),  rd_reg(1),               {6'h23, 5'd1, 5'd1, 5'd11, 5'd0, 6'h20},
      rd_reg(11)};
    logic [31:0] exp [21] = '{
      32'hFFFFFFFF, 32'h0000000F, 32'h80000000, 32'h0000000F,
      32'h0000001E, 32'hFFFFFFF1, 32'hFFFFFFFE, 32'h0000000F,
      32'h0000001F, 32'h00000001, 32'h00000000, 32'h00000000,
      32'h00000001, 32'hFFFFFFFE, 32'h80000000, 32'hFFFFFFFF,
      32'h00000000, 32'h00000000, 32'hFFFFFFFF, 32'h00000000,
      32'h00000000};
    foreach (ins[i]) begin
      instruction = ins[i];
      #1;
      n_cmp++;
      if (result !== exp[i]) begin n_err++; $display("FAIL directed[%0d] ins=%h got=%h want=%h", i, ins[i], result, exp[i]); end
      clock_in(ins[i]);
    end
  endtask

  task automatic test_random;
    logic [31:0] ins, v;
    for (int k = 0; k < 300; k++) begin
      ins = enc(($urandom_range(0, 9) == 0) ? 6'($urandom) : fns[$urandom_range(0, 9)],
                $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31));
      if ($urandom_range(0, 19) == 0) ins[31:26] = 6'($urandom_range(1, 63));
      instruction = ins;
      #1;
      v = model(ins);
      n_cmp++;
      if (result !== v) begin n_err++; $display("FAIL random[%0d] ins=%h got=%h want=%h", k, ins, result, v); end
      clock_in(ins);
    end
  endtask

  task automatic test_readback;
    for (int r = 0; r < 32; r++) begin
      instruction = rd_reg(r);
      #1;
      n_cmp++;
      if (result !== m[r]) begin n_err++; $display("FAIL readback $%0d got=%h want=%h", r, result, m[r]); end
    end
  endtask

  task automatic test_mid_reset;
    instruction = enc(6'h27, 0, 0, 14, 0);
    clock_in(instruction);
    instruction = enc(6'h20, 14, 0, 11, 0);
    #2;
    rst_n = 0;
    #1;
    foreach (m[i]) m[i] = 0;
    for (int r = 1; r < 32; r += 5) begin
      instruction = rd_reg(r);
      #0.5;
      n_cmp++;
      if (result !== 32'h0) begin n_err++; $display("FAIL midreset_clear $%0d got=%h want=00000000", r, result); end
    end
    instruction = rd_reg(14);
    #0.5;
    n_cmp++;
    if (result !== 32'h0) begin n_err++; $display("FAIL midreset_clear $14 got=%h want=00000000", result); end
    instruction = enc(6'h27, 0, 0, 12, 0);
    @(posedge clk);
    #3;
    instruction = rd_reg(0);
    rst_n = 1;
    #1;
    instruction = rd_reg(12);
    #1;
    n_cmp++;
    if (result !== 32'h0) begin n_err++; $display("FAIL midreset_write_blocked got=%h want=00000000", result); end
    instruction = enc(6'h27, 0, 0, 13, 0);
    clock_in(instruction);
    instruction = rd_reg(13);
    #1;
    n_cmp++;
    if (result !== 32'hFFFFFFFF) begin n_err++; $display("FAIL first_write_after_release got=%h want=ffffffff", result); end
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset;
    test_directed;
    test_random;
    test_readback;
    test_mid_reset;
    test_readback;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
